// File: rtl/fmax_reduce_if.sv
// fmax_reduce_if: stream bundle for the fmax_reduce block.
//   in_valid/in_ready/in_data/in_last : operand stream into the reducer
//   out_valid/out_ready/out_data/out_idx/out_nan : one result per packet
// master = upstream/downstream side (testbench or pipeline), slave = reducer.
interface fmax_reduce_if #(
    parameter int WE   = 5,
    parameter int WF   = 5,
    parameter int IDXW = 8
);
    logic                in_valid;
    logic                in_ready;
    logic [WE+WF+2:0]    in_data;
    logic                in_last;
    logic                out_valid;
    logic                out_ready;
    logic [WE+WF+2:0]    out_data;
    logic [IDXW-1:0]     out_idx;
    logic                out_nan;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_nan
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_nan
    );
endinterface

// File: rtl/fmax_reduce.sv
// fmax_reduce: streaming max-reduction over FloPoCo floats
//   (exc[1:0] | sign | exp[WE-1:0] | frac[WF-1:0]; exc 00=zero 01=normal
//   10=inf 11=NaN). Keeps a running maximum of a packet and returns the max,
//   its 0-based index and a sticky NaN flag once per packet.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : fmax_reduce_if.slave (input stream + result handshake)
// Also contains fcmplt, the combinational X<Y comparator it is built around.

// fcmplt: combinational FloPoCo less-than.
//   x, y      : operands
//   xlty      : x < y (0 when unordered; +0 and -0 compare equal)
//   unordered : either operand is NaN
module fcmplt #(
    parameter int WE = 5,
    parameter int WF = 5,
    parameter int ID = 1
) (
    input  logic [WE+WF+2:0] x,
    input  logic [WE+WF+2:0] y,
    output logic             xlty,
    output logic             unordered
);
    localparam int W = WE + WF + 3;

    logic [1:0]       ex, ey;
    logic             sx, sy;
    logic [WE+WF+1:0] mx, my;

    assign ex = x[W-1:W-2];
    assign ey = y[W-1:W-2];
    assign sx = x[W-3];
    assign sy = y[W-3];

    // Magnitude key: exc class on top (zero < normal < inf), exp/frac only
    // meaningful for normals so they are zeroed otherwise.
    assign mx = {ex, (ex == 2'b01) ? x[WE+WF-1:0] : {(WE+WF){1'b0}}};
    assign my = {ey, (ey == 2'b01) ? y[WE+WF-1:0] : {(WE+WF){1'b0}}};

    assign unordered = (ex == 2'b11) || (ey == 2'b11);

    always_comb begin
        xlty = 1'b0;
        if (!unordered) begin
            if (ex == 2'b00 && ey == 2'b00) xlty = 1'b0;   // +0 == -0
            else if (sx != sy)              xlty = sx;
            else if (!sx)                   xlty = (mx < my);
            else                            xlty = (mx > my);
        end
    end

    // ID only tags the instance; it has no effect on the logic.
    if (ID < 0) begin : g_id_tag
    end
endmodule

module fmax_reduce #(
    parameter int WE   = 5,
    parameter int WF   = 5,
    parameter int IDXW = 8,
    parameter int ID   = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    fmax_reduce_if.slave bus
);
    localparam int W = WE + WF + 3;

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

    state_t          state;
    logic [W-1:0]    max_r;
    logic [IDXW-1:0] idx_r;
    logic [IDXW-1:0] cnt;
    logic            nan_r;
    logic            out_valid_r;

    logic            xlty, unordered, accept, in_is_nan;
    logic [W-1:0]    nan_canon;

    assign nan_canon = {2'b11, {(W-2){1'b0}}};
    assign in_is_nan = (bus.in_data[W-1:W-2] == 2'b11);

    fcmplt #(.WE(WE), .WF(WF), .ID(ID)) u_cmp (
        .x         (max_r),
        .y         (bus.in_data),
        .xlty      (xlty),
        .unordered (unordered)
    );

    // Ready is held low while reset is asserted, not just until the first edge.
    assign bus.in_ready  = rst_n && (state != S_DONE);
    assign accept        = bus.in_valid && bus.in_ready;

    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = max_r;
    assign bus.out_idx   = idx_r;
    assign bus.out_nan   = nan_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            max_r       <= '0;
            idx_r       <= '0;
            cnt         <= '0;
            nan_r       <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    max_r <= bus.in_data;
                    idx_r <= '0;
                    cnt   <= {{(IDXW-1){1'b0}}, 1'b1};
                    nan_r <= in_is_nan;
                    if (bus.in_last) begin
                        state       <= S_DONE;
                        out_valid_r <= 1'b1;
                    end else begin
                        state <= S_ACC;
                    end
                end
                S_ACC: if (accept) begin
                    // With nan_r clear, max_r is never NaN, so unordered
                    // here means the incoming beat is the first NaN.
                    if (unordered && !nan_r) begin
                        nan_r <= 1'b1;
                        max_r <= nan_canon;
                        idx_r <= cnt;
                    end else if (!nan_r && xlty) begin
                        max_r <= bus.in_data;
                        idx_r <= cnt;
                    end
                    if (cnt != '1) cnt <= cnt + 1'b1;
                    if (bus.in_last) begin
                        state       <= S_DONE;
                        out_valid_r <= 1'b1;
                    end
                end
                S_DONE: if (out_valid_r && bus.out_ready) begin
                    state       <= S_IDLE;
                    out_valid_r <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
